// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/enable controller: synchronises 16 raw request lines, latches
// pending bits and hands the priority-encoded winner to a consumer with a req/ack handshake.
module irq_pending_ctrl #(
  parameter bit LEVEL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] irq_in,
  input  logic        en_wr,
  input  logic [15:0] en_wdata,
  output logic [15:0] en_q,
  output logic [15:0] pend_q,
  output logic [15:0] pend_vec,
  input  logic [3:0]  enc_id,
  input  logic        enc_valid,
  output logic        irq_req,
  output logic [3:0]  irq_id,
  input  logic        irq_ack
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e      state_q;
  logic [15:0] s1_q, s2_q, s3_q;
  logic [15:0] set_vec, clr_vec;
  logic [15:0] pend_d, en_d;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would collapse the s1 -> s2 -> s3 chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= irq_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise a partial
  // assignment (clr_vec below) infers a latch.
  always_comb begin
    set_vec = LEVEL ? s2_q : (s2_q & ~s3_q);
    clr_vec = '0;
    if (state_q == REQ && irq_ack) clr_vec[irq_id] = 1'b1;
    // Set is OR-ed in after the clear so a fresh capture on the ack edge survives.
    pend_d  = (pend_q & ~clr_vec) | set_vec;
    en_d    = en_wr ? en_wdata : en_q;
  end

  assign pend_vec = pend_q & en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      en_q   <= '0;
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
    end
  end

  // irq_id is latched on entry to REQ so later enable writes or new pendings cannot move it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_valid) begin
            irq_id  <= enc_id;
            irq_req <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            irq_req <= 1'b0;
            state_q <= GAP;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          irq_req <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl (LEVEL=0) with a behavioural 16x4 priority encoder.
module tb_irq_pending_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] irq_in;
  logic        en_wr;
  logic [15:0] en_wdata;
  logic [15:0] en_q, pend_q, pend_vec;
  logic [3:0]  enc_id;
  logic        enc_valid;
  logic        irq_req;
  logic [3:0]  irq_id;
  logic        irq_ack;

  int n_checks = 0;
  int n_fail   = 0;

  irq_pending_ctrl #(.LEVEL(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .en_wr     (en_wr),
    .en_wdata  (en_wdata),
    .en_q      (en_q),
    .pend_q    (pend_q),
    .pend_vec  (pend_vec),
    .enc_id    (enc_id),
    .enc_valid (enc_valid),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack)
  );

  always #5 clk = ~clk;

  // External priority encoder: highest set bit wins.
  always_comb begin
    enc_valid = |pend_vec;
    enc_id    = 4'd0;
    for (int i = 0; i < 16; i++) if (pend_vec[i]) enc_id = 4'(i);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_en(input logic [15:0] v);
    en_wr = 1'b1; en_wdata = v;
    tick(1);
    en_wr = 1'b0;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq_in = 16'h0004; en_wr = 1'b0; en_wdata = '0; irq_ack = 1'b0;
    #12;
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", irq_req); end
    n_checks++; if (irq_id !== 4'd0) begin n_fail++; $display("FAIL rst_id: got %0d want 0", irq_id); end
    n_checks++; if (pend_q !== 16'h0000) begin n_fail++; $display("FAIL rst_pend: got %h want 0000", pend_q); end
    n_checks++; if (en_q !== 16'h0000) begin n_fail++; $display("FAIL rst_en: got %h want 0000", en_q); end
    // irq_in[2] held high through release counts as a rising edge
    rst_n = 1'b1;
    tick(2);
    n_checks++; if (pend_q !== 16'h0000) begin n_fail++; $display("FAIL held_edge_early: got %h want 0000", pend_q); end
    tick(1);
    n_checks++; if (pend_q !== 16'h0004) begin n_fail++; $display("FAIL held_edge: got %h want 0004", pend_q); end
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL held_masked: got %b want 0", irq_req); end
    rst_n = 1'b0; irq_in = '0;
    #1;
    n_checks++; if (pend_q !== 16'h0000) begin n_fail++; $display("FAIL rst_async_pend: got %h want 0000", pend_q); end
    tick(1);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_single();
    write_en(16'hFFFF);
    irq_in[5] = 1'b1;
    tick(2);
    n_checks++; if (pend_q !== 16'h0000) begin n_fail++; $display("FAIL single_pend_e1: got %h want 0000", pend_q); end
    tick(1);
    n_checks++; if (pend_q !== 16'h0020) begin n_fail++; $display("FAIL single_pend_e2: got %h want 0020", pend_q); end
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL single_req_e2: got %b want 0", irq_req); end
    tick(1);
    n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL single_req_e3: got %b want 1", irq_req); end
    n_checks++; if (irq_id !== 4'd5) begin n_fail++; $display("FAIL single_id: got %0d want 5", irq_id); end
    tick(2);
    n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL single_hold: got %b want 1", irq_req); end
    ack_pulse();
    n_checks++; if (pend_q !== 16'h0000) begin n_fail++; $display("FAIL single_clr: got %h want 0000", pend_q); end
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL single_drop: got %b want 0", irq_req); end
    irq_in = '0;
    tick(4);
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL single_no_retrig: got %b want 0", irq_req); end
  endtask

  task automatic test_back_to_back();
    irq_in = 16'h1008;
    tick(3);
    n_checks++; if (pend_q !== 16'h1008) begin n_fail++; $display("FAIL b2b_pend: got %h want 1008", pend_q); end
    tick(1);
    n_checks++; if (irq_id !== 4'd12 || irq_req !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got req=%b id=%0d want req=1 id=12", irq_req, irq_id); end
    ack_pulse();
    n_checks++; if (pend_q !== 16'h0008) begin n_fail++; $display("FAIL b2b_clr12: got %h want 0008", pend_q); end
    tick(1);
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b want 0", irq_req); end
    tick(1);
    n_checks++; if (irq_id !== 4'd3 || irq_req !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got req=%b id=%0d want req=1 id=3", irq_req, irq_id); end
    ack_pulse();
    n_checks++; if (pend_q !== 16'h0000) begin n_fail++; $display("FAIL b2b_clr3: got %h want 0000", pend_q); end
    irq_in = '0;
    tick(3);
  endtask

  task automatic test_masked();
    write_en(16'h0000);
    irq_in[7] = 1'b1;
    tick(1);
    irq_in[7] = 1'b0;
    tick(2);
    n_checks++; if (pend_q !== 16'h0080) begin n_fail++; $display("FAIL mask_pend: got %h want 0080", pend_q); end
    // ack outside REQ must not clear anything
    ack_pulse();
    tick(2);
    n_checks++; if (pend_q !== 16'h0080) begin n_fail++; $display("FAIL mask_idle_ack: got %h want 0080", pend_q); end
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL mask_no_req: got %b want 0", irq_req); end
    write_en(16'h0080);
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL mask_en_edge: got %b want 0", irq_req); end
    tick(1);
    n_checks++; if (irq_id !== 4'd7 || irq_req !== 1'b1) begin n_fail++; $display("FAIL mask_unmask: got req=%b id=%0d want req=1 id=7", irq_req, irq_id); end
    ack_pulse();
    tick(1);
    write_en(16'hFFFF);
  endtask

  task automatic test_set_wins();
    irq_in[9] = 1'b1;
    tick(4);
    n_checks++; if (irq_id !== 4'd9 || irq_req !== 1'b1) begin n_fail++; $display("FAIL sw_req: got req=%b id=%0d want req=1 id=9", irq_req, irq_id); end
    irq_in[9] = 1'b0;
    irq_in[14] = 1'b1;
    tick(3);
    n_checks++; if (irq_id !== 4'd9 || irq_req !== 1'b1) begin n_fail++; $display("FAIL sw_stable: got req=%b id=%0d want req=1 id=9", irq_req, irq_id); end
    // new edge on line 9 lands on the same edge as the ack
    irq_in[9] = 1'b1;
    tick(2);
    ack_pulse();
    n_checks++; if (pend_q !== 16'h4200) begin n_fail++; $display("FAIL sw_set_wins: got %h want 4200", pend_q); end
    tick(2);
    n_checks++; if (irq_id !== 4'd14 || irq_req !== 1'b1) begin n_fail++; $display("FAIL sw_next14: got req=%b id=%0d want req=1 id=14", irq_req, irq_id); end
    ack_pulse();
    tick(2);
    n_checks++; if (irq_id !== 4'd9 || irq_req !== 1'b1) begin n_fail++; $display("FAIL sw_again9: got req=%b id=%0d want req=1 id=9", irq_req, irq_id); end
    ack_pulse();
    n_checks++; if (pend_q !== 16'h0000) begin n_fail++; $display("FAIL sw_clr: got %h want 0000", pend_q); end
    irq_in = '0;
    tick(3);
  endtask

  task automatic test_disable_in_req();
    irq_in[1] = 1'b1;
    tick(4);
    write_en(16'h0000);
    n_checks++; if (irq_id !== 4'd1 || irq_req !== 1'b1) begin n_fail++; $display("FAIL dis_hold: got req=%b id=%0d want req=1 id=1", irq_req, irq_id); end
    ack_pulse();
    n_checks++; if (pend_q !== 16'h0000) begin n_fail++; $display("FAIL dis_clr: got %h want 0000", pend_q); end
    irq_in = '0;
    tick(3);
    write_en(16'hFFFF);
  endtask

  task automatic test_reset_mid();
    irq_in = 16'h8001;
    tick(4);
    n_checks++; if (pend_q !== 16'h8001 || irq_req !== 1'b1 || irq_id !== 4'd15) begin n_fail++; $display("FAIL mid_setup: got pend=%h req=%b id=%0d want 8001 1 15", pend_q, irq_req, irq_id); end
    #2 rst_n = 1'b0;
    irq_in = '0;
    #1;
    n_checks++; if (irq_req !== 1'b0 || pend_q !== 16'h0000 || en_q !== 16'h0000) begin n_fail++; $display("FAIL mid_reset: got req=%b pend=%h en=%h want 0 0000 0000", irq_req, pend_q, en_q); end
    tick(1);
    rst_n = 1'b1;
    irq_in[4] = 1'b1;
    tick(6);
    n_checks++; if (pend_q !== 16'h0010 || irq_req !== 1'b0) begin n_fail++; $display("FAIL mid_no_req: got pend=%h req=%b want 0010 0", pend_q, irq_req); end
    write_en(16'h0010);
    tick(1);
    n_checks++; if (irq_id !== 4'd4 || irq_req !== 1'b1) begin n_fail++; $display("FAIL mid_after_en: got req=%b id=%0d want req=1 id=4", irq_req, irq_id); end
    ack_pulse();
    irq_in = '0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_masked();
    test_set_wins();
    test_disable_in_req();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 Parameter LEVEL, default 0: 0 = rising-edge capture, 1 = level capture of irq_in.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 irq_in  input  16  raw asynchronous request lines; bit 15 = highest priority.
REQ-005 en_wr  input  1  enable-register write strobe.
REQ-006 en_wdata  input  16  enable-register write data; 1 = line enabled.
REQ-007 en_q  output  16  current enable register.
REQ-008 pend_q  output  16  raw pending register.
REQ-009 pend_vec  output  16  pend_q & en_q, combinational; drives the 16x4 priority encoder input.
REQ-010 enc_id  input  4  encoded index returned by the priority encoder.
REQ-011 enc_valid  input  1  encoder valid; high when pend_vec is non-zero.
REQ-012 irq_req  output  1  request to consumer.
REQ-013 irq_id  output  4  index of the serviced line; valid while irq_req is high.
REQ-014 irq_ack  input  1  consumer acknowledge; single-cycle pulse.

Function
REQ-015 Each irq_in bit SHALL pass through a 2-flop synchroniser (s1, s2) plus a history flop s3.
REQ-016 LEVEL=0: pend_q[i] SHALL set when s2[i]=1 and s3[i]=0; LEVEL=1: pend_q[i] SHALL set whenever s2[i]=1.
REQ-017 Pending capture SHALL be independent of en_q; masked lines stay pending and appear on pend_vec once enabled.
REQ-018 irq_in rising before edge 0 SHALL set pend_q on edge 2 (s1 at edge 0, s2 at edge 1, pend_q at edge 2).
REQ-019 en_wr=1 SHALL load en_q from en_wdata on that edge.
REQ-020 FSM states: IDLE, REQ, GAP.
REQ-021 IDLE: when enc_valid=1, SHALL load irq_id<=enc_id, set irq_req=1, go to REQ; otherwise remain in IDLE.
REQ-022 REQ: irq_req and irq_id SHALL hold stable until irq_ack; enable writes or new pendings SHALL NOT alter irq_id or withdraw irq_req.
REQ-023 REQ with irq_ack=1: SHALL clear pend_q[irq_id], drop irq_req, go to GAP on the same edge.
REQ-024 GAP: irq_req SHALL remain 0 for exactly one cycle, then go to IDLE, so the encoder settles on the updated pend_vec.
REQ-025 irq_ack in IDLE or GAP SHALL be ignored.
REQ-026 Set and clear of the same pend_q bit on the same edge: set SHALL win.
REQ-027 A line with pend_q=1 that is disabled while in REQ SHALL still be serviced; its pend_q bit SHALL clear on ack.
REQ-028 Back-to-back service: minimum period from one irq_req rise to the next SHALL be 3 cycles (REQ acked immediately, GAP, IDLE).
REQ-029 Latency SHALL be irq_req high at edge 3 after irq_in rises, given the line is enabled and the FSM is idle.

Reset
REQ-030 rst_n low SHALL immediately force: s1/s2/s3=0, pend_q=0, en_q=16'h0000, irq_req=0, irq_id=0, FSM=IDLE.
REQ-031 Reset asserted mid-handshake SHALL drop irq_req asynchronously and discard all pending requests.
REQ-032 irq_in held high through reset release SHALL register as a rising edge (s3=0) in LEVEL=0.

Verification
REQ-033 en_q=16'hFFFF, irq_in[5] rises -> pend_q=16'h0020 at edge 2; irq_req=1, irq_id=5 at edge 3; ack -> pend_q=0, irq_req=0.
REQ-034 en_q=16'hFFFF, irq_in[3] and irq_in[12] rise together -> irq_id=12 first; after ack and GAP, irq_id=3.
REQ-035 en_q=16'h0000, irq_in[7] pulses -> pend_q[7]=1, irq_req stays 0; write en_q=16'h0080 -> irq_req=1, irq_id=7 one edge later.
REQ-036 In REQ with irq_id=9, a new edge on irq_in[9] timed to set on the ack edge -> pend_q[9] stays 1; irq_req reasserts with irq_id=9 after GAP.
REQ-037 rst_n pulled low while irq_req=1 and pend_q=16'h8001 -> immediately irq_req=0, pend_q=0, en_q=0; after release, no request occurs until en_q is written.
